// File: rtl/exc_arbiter.sv
// exc_arbiter: commit-stage exception/interrupt arbiter sitting in front of CP0.
// Picks one event per accepted commit, drives the CP0 write port and redirects fetch.
//
// state  | meaning
// IDLE   | accepting commits from the commit stage
// DRAIN  | post-flush window, commit inputs ignored until the counter expires
module exc_arbiter #(
  parameter int unsigned DRAIN_CYCLES = 2,
  parameter logic [31:0] BEV_BASE     = 32'hBFC00200
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  ext_int,
  output logic [5:0]  hw_int,
  input  logic        c_valid,
  input  logic        c_stall,
  input  logic [31:0] c_pc,
  input  logic        c_bd,
  input  logic        c_if_adel,
  input  logic        c_if_refill,
  input  logic        c_if_inv,
  input  logic        c_ri,
  input  logic        c_sys,
  input  logic        c_bp,
  input  logic        c_ov,
  input  logic        c_eret,
  input  logic        c_d_adel,
  input  logic        c_d_ades,
  input  logic        c_d_refill,
  input  logic        c_d_inv,
  input  logic        c_d_mod,
  input  logic        c_d_store,
  input  logic [31:0] c_dvaddr,
  input  logic        allow_int,
  input  logic [7:0]  interrupt_flag,
  input  logic        sr_bev,
  input  logic        sr_exl,
  input  logic [31:0] ebase,
  input  logic [31:0] epc,
  output logic        en_exp,
  output logic        exp_bd,
  output logic [31:0] exp_epc,
  output logic [4:0]  exc_code,
  output logic [31:0] exp_badvaddr,
  output logic        exp_badvaddr_we,
  output logic        clear_exl,
  output logic        flush,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc
);

  typedef enum logic {S_IDLE = 1'b0, S_DRAIN = 1'b1} state_t;
  localparam logic [3:0] DRAIN_LD = 4'(DRAIN_CYCLES);

  state_t      r_state, w_state_nxt;
  logic [3:0]  r_cnt, w_cnt_nxt;
  logic [5:0]  r_sync1, r_sync2;

  logic        w_accept, w_int, w_is_exc, w_is_eret, w_bad_we, w_refill;
  logic        w_fire_exc, w_fire_eret;
  logic [4:0]  w_code;
  logic [31:0] w_bad, w_vector, w_epc_val, w_base;

  logic        r_en_exp, r_exp_bd, r_bad_we, r_clear_exl, r_flush, r_redirect_valid;
  logic [31:0] r_exp_epc, r_badvaddr, r_redirect_pc;
  logic [4:0]  r_exc_code;

  assign w_accept = (r_state == S_IDLE) & c_valid & ~c_stall;
  assign w_int    = allow_int & (|interrupt_flag);

  always_comb begin
    w_is_exc  = 1'b1;
    w_is_eret = 1'b0;
    w_code    = 5'd0;
    w_bad_we  = 1'b0;
    w_bad     = 32'd0;
    w_refill  = 1'b0;
    if (w_int) begin
      w_code = 5'd0;
    end else if (c_if_adel) begin
      w_code = 5'd4;  w_bad_we = 1'b1; w_bad = c_pc;
    end else if (c_if_refill | c_if_inv) begin
      w_code = 5'd2;  w_bad_we = 1'b1; w_bad = c_pc; w_refill = c_if_refill;
    end else if (c_ri) begin
      w_code = 5'd10;
    end else if (c_sys) begin
      w_code = 5'd8;
    end else if (c_bp) begin
      w_code = 5'd9;
    end else if (c_ov) begin
      w_code = 5'd12;
    end else if (c_d_adel) begin
      w_code = 5'd4;  w_bad_we = 1'b1; w_bad = c_dvaddr;
    end else if (c_d_ades) begin
      w_code = 5'd5;  w_bad_we = 1'b1; w_bad = c_dvaddr;
    end else if (c_d_refill | c_d_inv) begin
      w_code = c_d_store ? 5'd3 : 5'd2;
      w_bad_we = 1'b1; w_bad = c_dvaddr; w_refill = c_d_refill;
    end else if (c_d_mod) begin
      w_code = 5'd1;  w_bad_we = 1'b1; w_bad = c_dvaddr;
    end else begin
      w_is_exc  = 1'b0;
      w_is_eret = c_eret;
    end
  end

  assign w_fire_exc  = w_accept & w_is_exc;
  assign w_fire_eret = w_accept & w_is_eret;

  // Only a TLB refill taken outside EXL uses the fast refill vector at offset 0.
  assign w_base    = sr_bev ? BEV_BASE : ebase;
  assign w_vector  = w_base + ((w_refill & ~sr_exl) ? 32'h0000_0000 : 32'h0000_0180);
  assign w_epc_val = c_bd ? (c_pc - 32'd4) : c_pc;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_fire_exc | w_fire_eret) begin
          w_state_nxt = S_DRAIN;
          w_cnt_nxt   = DRAIN_LD;
        end
      end
      S_DRAIN: begin
        w_cnt_nxt = r_cnt - 4'd1;
        if (r_cnt <= 4'd1) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = 4'd0;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state          <= S_IDLE;
      r_cnt            <= 4'd0;
      r_sync1          <= 6'd0;
      r_sync2          <= 6'd0;
      r_en_exp         <= 1'b0;
      r_exp_bd         <= 1'b0;
      r_exp_epc        <= 32'd0;
      r_exc_code       <= 5'd0;
      r_badvaddr       <= 32'd0;
      r_bad_we         <= 1'b0;
      r_clear_exl      <= 1'b0;
      r_flush          <= 1'b0;
      r_redirect_valid <= 1'b0;
      r_redirect_pc    <= 32'd0;
    end else begin
      r_state          <= w_state_nxt;
      r_cnt            <= w_cnt_nxt;
      r_sync1          <= ext_int;
      r_sync2          <= r_sync1;
      r_en_exp         <= w_fire_exc;
      r_exp_bd         <= w_fire_exc & c_bd;
      r_exp_epc        <= w_fire_exc ? w_epc_val : 32'd0;
      r_exc_code       <= w_fire_exc ? w_code : 5'd0;
      r_badvaddr       <= w_fire_exc ? w_bad : 32'd0;
      r_bad_we         <= w_fire_exc & w_bad_we;
      r_clear_exl      <= w_fire_eret;
      r_flush          <= w_fire_exc | w_fire_eret;
      r_redirect_valid <= w_fire_exc | w_fire_eret;
      r_redirect_pc    <= w_fire_exc ? w_vector : (w_fire_eret ? epc : 32'd0);
    end
  end

  assign hw_int          = r_sync2;
  assign en_exp          = r_en_exp;
  assign exp_bd          = r_exp_bd;
  assign exp_epc         = r_exp_epc;
  assign exc_code        = r_exc_code;
  assign exp_badvaddr    = r_badvaddr;
  assign exp_badvaddr_we = r_bad_we;
  assign clear_exl       = r_clear_exl;
  assign flush           = r_flush;
  assign redirect_valid  = r_redirect_valid;
  assign redirect_pc     = r_redirect_pc;

endmodule

// File: tb/tb_exc_arbiter.sv
// Testbench for exc_arbiter: directed vector table, hand sequences for drain/stall/reset,
// then random commits compared against a priority-table reference model.
module tb_exc_arbiter;

  localparam int          DRAIN = 2;
  localparam logic [31:0] BEV   = 32'hBFC00200;

  typedef struct packed {
    logic        rst;
    logic [5:0]  ext_int;
    logic        c_valid, c_stall;
    logic [31:0] c_pc;
    logic        c_bd, c_if_adel, c_if_refill, c_if_inv, c_ri, c_sys, c_bp, c_ov, c_eret;
    logic        c_d_adel, c_d_ades, c_d_refill, c_d_inv, c_d_mod, c_d_store;
    logic [31:0] c_dvaddr;
    logic        allow_int;
    logic [7:0]  interrupt_flag;
    logic        sr_bev, sr_exl;
    logic [31:0] ebase, epc;
  } in_t;

  typedef struct packed {
    logic        en_exp, exp_bd;
    logic [31:0] exp_epc;
    logic [4:0]  exc_code;
    logic [31:0] badvaddr;
    logic        bad_we, clear_exl, flush, rv;
    logic [31:0] rpc;
  } out_t;

  typedef struct {
    string name;
    in_t   i;
    out_t  o;
  } vec_t;

  logic  clk;
  in_t   cur;
  out_t  dut_out;
  logic  en_exp, exp_bd, exp_badvaddr_we, clear_exl, flush, redirect_valid;
  logic [31:0] exp_epc, exp_badvaddr, redirect_pc;
  logic [4:0]  exc_code;
  logic [5:0]  hw_int;

  int n_checks = 0;
  int n_err    = 0;
  int m_block  = 0;
  logic [5:0] m_hist[$];

  exc_arbiter #(.DRAIN_CYCLES(DRAIN), .BEV_BASE(BEV)) dut (
    .clk(clk), .rst(cur.rst), .ext_int(cur.ext_int), .hw_int(hw_int),
    .c_valid(cur.c_valid), .c_stall(cur.c_stall), .c_pc(cur.c_pc), .c_bd(cur.c_bd),
    .c_if_adel(cur.c_if_adel), .c_if_refill(cur.c_if_refill), .c_if_inv(cur.c_if_inv),
    .c_ri(cur.c_ri), .c_sys(cur.c_sys), .c_bp(cur.c_bp), .c_ov(cur.c_ov), .c_eret(cur.c_eret),
    .c_d_adel(cur.c_d_adel), .c_d_ades(cur.c_d_ades), .c_d_refill(cur.c_d_refill),
    .c_d_inv(cur.c_d_inv), .c_d_mod(cur.c_d_mod), .c_d_store(cur.c_d_store),
    .c_dvaddr(cur.c_dvaddr), .allow_int(cur.allow_int), .interrupt_flag(cur.interrupt_flag),
    .sr_bev(cur.sr_bev), .sr_exl(cur.sr_exl), .ebase(cur.ebase), .epc(cur.epc),
    .en_exp(en_exp), .exp_bd(exp_bd), .exp_epc(exp_epc), .exc_code(exc_code),
    .exp_badvaddr(exp_badvaddr), .exp_badvaddr_we(exp_badvaddr_we), .clear_exl(clear_exl),
    .flush(flush), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  assign dut_out = {en_exp, exp_bd, exp_epc, exc_code, exp_badvaddr, exp_badvaddr_we,
                    clear_exl, flush, redirect_valid, redirect_pc};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic in_t base_in();
    in_t x = '0;
    x.ebase = 32'h8000_0000;
    return x;
  endfunction

  function automatic out_t mk_out(input logic en, input logic bd, input logic [31:0] e,
                                  input logic [4:0] code, input logic [31:0] bad,
                                  input logic we, input logic clr, input logic [31:0] rpc);
    out_t o;
    o = '{en_exp: en, exp_bd: bd, exp_epc: e, exc_code: code, badvaddr: bad, bad_we: we,
          clear_exl: clr, flush: en | clr, rv: en | clr, rpc: rpc};
    return o;
  endfunction

  // Priority list: first matching row decides the event; src 0=none, 1=c_pc, 2=c_dvaddr.
  function automatic out_t ref_event(input in_t x);
    logic       cond [11];
    logic [4:0] code [11];
    int         src  [11];
    logic       refl [11];
    out_t       o = '0;
    logic [31:0] vbase;
    cond = '{x.allow_int && (x.interrupt_flag != 8'd0), x.c_if_adel, x.c_if_refill || x.c_if_inv,
             x.c_ri, x.c_sys, x.c_bp, x.c_ov, x.c_d_adel || x.c_d_ades,
             x.c_d_refill || x.c_d_inv, x.c_d_mod, x.c_eret};
    code = '{5'd0, 5'd4, 5'd2, 5'd10, 5'd8, 5'd9, 5'd12, (x.c_d_adel ? 5'd4 : 5'd5),
             (x.c_d_store ? 5'd3 : 5'd2), 5'd1, 5'd0};
    src  = '{0, 1, 1, 0, 0, 0, 0, 2, 2, 2, 0};
    refl = '{1'b0, 1'b0, x.c_if_refill, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, x.c_d_refill, 1'b0, 1'b0};
    for (int k = 0; k < 11; k++) begin
      if (cond[k]) begin
        if (k == 10) begin
          o.clear_exl = 1'b1; o.flush = 1'b1; o.rv = 1'b1; o.rpc = x.epc;
        end else begin
          vbase      = x.sr_bev ? BEV : x.ebase;
          o.en_exp   = 1'b1;
          o.exp_bd   = x.c_bd;
          o.exp_epc  = x.c_pc - (x.c_bd ? 32'd4 : 32'd0);
          o.exc_code = code[k];
          o.bad_we   = (src[k] != 0);
          o.badvaddr = (src[k] == 1) ? x.c_pc : ((src[k] == 2) ? x.c_dvaddr : 32'd0);
          o.flush    = 1'b1;
          o.rv       = 1'b1;
          o.rpc      = vbase + ((refl[k] && !x.sr_exl) ? 32'd0 : 32'h180);
        end
        return o;
      end
    end
    return o;
  endfunction

  task automatic model_step(input in_t x, output out_t o, output logic [5:0] hw);
    bit acc;
    if (x.rst) begin
      o = '0; m_block = 0; m_hist.delete(); hw = 6'd0;
    end else begin
      m_hist.push_back(x.ext_int);
      if (m_hist.size() > 2) void'(m_hist.pop_front());
      hw  = (m_hist.size() == 2) ? m_hist[0] : 6'd0;
      acc = (m_block == 0) && x.c_valid && !x.c_stall;
      o   = acc ? ref_event(x) : out_t'('0);
      if (o.flush) m_block = DRAIN;
      else if (m_block > 0) m_block--;
    end
  endtask

  task automatic cycle(input in_t x, output out_t got, output out_t mdl,
                       output logic [5:0] hw_got, output logic [5:0] hw_mdl);
    cur = x;
    model_step(x, mdl, hw_mdl);
    @(posedge clk);
    #1;
    got    = dut_out;
    hw_got = hw_int;
  endtask

  task automatic chk_out(input string nm, input out_t got, input out_t exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic chk_hw(input string nm, input logic [5:0] got, input logic [5:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: hw_int got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic idle(input int n, input string nm);
    in_t x; out_t g, m; logic [5:0] hg, hm;
    x = base_in();
    for (int k = 0; k < n; k++) begin
      cycle(x, g, m, hg, hm);
      if (k == 0) chk_out(nm, g, '0);
    end
  endtask

  vec_t tbl[$];

  initial begin
    in_t x, t;
    out_t g, m;
    logic [5:0] hg, hm;

    t = base_in(); t.c_valid = 1; t.c_pc = 32'h80001000; t.c_sys = 1;
    tbl.push_back('{"sys", t, mk_out(1, 0, 32'h80001000, 8, 0, 0, 0, 32'h80000180)});
    t = base_in(); t.c_valid = 1; t.c_bd = 1; t.c_pc = 32'h80002004; t.c_d_refill = 1;
    t.c_d_store = 1; t.c_dvaddr = 32'h00401234;
    tbl.push_back('{"ds_tlbs", t, mk_out(1, 1, 32'h80002000, 3, 32'h00401234, 1, 0, 32'h80000000)});
    t.sr_exl = 1;
    tbl.push_back('{"ds_tlbs_exl", t, mk_out(1, 1, 32'h80002000, 3, 32'h00401234, 1, 0, 32'h80000180)});
    t = base_in(); t.c_valid = 1; t.c_pc = 32'h80003000; t.allow_int = 1; t.interrupt_flag = 8'h80; t.c_ri = 1;
    tbl.push_back('{"int_over_ri", t, mk_out(1, 0, 32'h80003000, 0, 0, 0, 0, 32'h80000180)});
    t = base_in(); t.c_valid = 1; t.c_pc = 32'h80004001; t.c_if_adel = 1; t.c_ov = 1; t.interrupt_flag = 8'h80;
    tbl.push_back('{"adel_over_ov", t, mk_out(1, 0, 32'h80004001, 4, 32'h80004001, 1, 0, 32'h80000180)});
    t = base_in(); t.c_valid = 1; t.c_pc = 32'h80005000; t.c_eret = 1; t.epc = 32'hBFC00100;
    tbl.push_back('{"eret", t, mk_out(0, 0, 0, 0, 0, 0, 1, 32'hBFC00100)});
    t = base_in(); t.c_valid = 1; t.c_pc = 32'h00400000; t.c_if_refill = 1; t.sr_bev = 1;
    tbl.push_back('{"bev_if_refill", t, mk_out(1, 0, 32'h00400000, 2, 32'h00400000, 1, 0, 32'hBFC00200)});
    t = base_in(); t.c_valid = 1; t.c_pc = 32'h80006000; t.c_d_mod = 1; t.c_dvaddr = 32'h12345678;
    tbl.push_back('{"mod", t, mk_out(1, 0, 32'h80006000, 1, 32'h12345678, 1, 0, 32'h80000180)});
    t = base_in(); t.c_valid = 1; t.c_pc = 32'h80007000; t.c_d_ades = 1; t.c_d_refill = 1; t.c_dvaddr = 32'h3;
    tbl.push_back('{"ades_over_tlb", t, mk_out(1, 0, 32'h80007000, 5, 32'h3, 1, 0, 32'h80000180)});
    t = base_in(); t.c_valid = 1; t.c_pc = 32'h80007100;
    tbl.push_back('{"no_event", t, out_t'('0)});
    t = base_in(); t.c_valid = 1; t.c_pc = 32'h80007200; t.interrupt_flag = 8'hFF;
    tbl.push_back('{"int_masked", t, out_t'('0)});
    t = base_in(); t.c_valid = 1; t.c_pc = 32'h80008000; t.c_if_inv = 1;
    tbl.push_back('{"if_inv", t, mk_out(1, 0, 32'h80008000, 2, 32'h80008000, 1, 0, 32'h80000180)});
    t = base_in(); t.c_valid = 1; t.c_bd = 1; t.c_pc = 32'h0; t.c_sys = 1;
    tbl.push_back('{"epc_wrap", t, mk_out(1, 1, 32'hFFFFFFFC, 8, 0, 0, 0, 32'h80000180)});
    t = base_in(); t.c_valid = 1; t.c_pc = 32'h80009000; t.c_d_refill = 1; t.c_dvaddr = 32'h10;
    t.sr_exl = 1; t.ebase = 32'hFFFFFF00;
    tbl.push_back('{"vec_wrap", t, mk_out(1, 0, 32'h80009000, 2, 32'h10, 1, 0, 32'h00000080)});
    t = base_in(); t.c_valid = 1; t.c_pc = 32'h8000A000; t.c_bp = 1; t.c_ov = 1;
    tbl.push_back('{"bp_over_ov", t, mk_out(1, 0, 32'h8000A000, 9, 0, 0, 0, 32'h80000180)});

    // Reset and synchroniser latency
    x = base_in(); x.rst = 1; x.ext_int = 6'h3F;
    for (int k = 0; k < 3; k++) begin
      cycle(x, g, m, hg, hm);
      chk_out("reset_out", g, '0);
      chk_hw("reset_hw", hg, 6'h00);
    end
    x.rst = 0;
    cycle(x, g, m, hg, hm);
    chk_hw("sync_lat1", hg, 6'h00);
    cycle(x, g, m, hg, hm);
    chk_hw("sync_lat2", hg, 6'h3F);
    chk_out("post_reset_out", g, '0);

    foreach (tbl[k]) begin
      cycle(tbl[k].i, g, m, hg, hm);
      chk_out(tbl[k].name, g, tbl[k].o);
      idle(DRAIN + 1, {tbl[k].name, "_pulse_end"});
    end

    // ERET followed by syscalls inside the drain window
    x = base_in(); x.c_valid = 1; x.c_eret = 1; x.epc = 32'hBFC00100; x.c_pc = 32'h80001000;
    cycle(x, g, m, hg, hm);
    chk_out("eret_seq", g, mk_out(0, 0, 0, 0, 0, 0, 1, 32'hBFC00100));
    x = base_in(); x.c_valid = 1; x.c_sys = 1; x.c_pc = 32'h80001000;
    cycle(x, g, m, hg, hm);
    chk_out("drain_ign1", g, '0);
    cycle(x, g, m, hg, hm);
    chk_out("drain_ign2", g, '0);
    cycle(x, g, m, hg, hm);
    chk_out("after_drain_sys", g, mk_out(1, 0, 32'h80001000, 8, 0, 0, 0, 32'h80000180));
    idle(DRAIN + 1, "after_drain_end");

    // Stall holds off both exceptions and pending interrupts
    x = base_in(); x.c_valid = 1; x.c_stall = 1; x.c_sys = 1; x.c_pc = 32'h80002000;
    cycle(x, g, m, hg, hm);
    chk_out("stall_sys", g, '0);
    x = base_in(); x.c_valid = 1; x.c_stall = 1; x.allow_int = 1; x.interrupt_flag = 8'h04;
    x.c_pc = 32'h80002100;
    cycle(x, g, m, hg, hm);
    chk_out("stall_int", g, '0);
    x.c_stall = 0;
    cycle(x, g, m, hg, hm);
    chk_out("unstall_int", g, mk_out(1, 0, 32'h80002100, 0, 0, 0, 0, 32'h80000180));
    idle(DRAIN + 1, "unstall_end");

    // Reset asserted during the drain window
    x = base_in(); x.c_valid = 1; x.c_sys = 1; x.c_pc = 32'h80003000;
    cycle(x, g, m, hg, hm);
    chk_out("pre_rst_sys", g, mk_out(1, 0, 32'h80003000, 8, 0, 0, 0, 32'h80000180));
    x.rst = 1;
    cycle(x, g, m, hg, hm);
    chk_out("rst_in_drain", g, '0);
    x.rst = 0;
    cycle(x, g, m, hg, hm);
    chk_out("sys_after_rst", g, mk_out(1, 0, 32'h80003000, 8, 0, 0, 0, 32'h80000180));
    idle(DRAIN + 1, "rst_seq_end");

    // Random commits against the reference model
    for (int n = 0; n < 1500; n++) begin
      x = '0;
      x.rst            = ($urandom_range(99) == 0);
      x.ext_int        = 6'($urandom);
      x.c_valid        = ($urandom_range(3) != 0);
      x.c_stall        = ($urandom_range(4) == 0);
      x.c_pc           = {$urandom_range(1) ? 4'h8 : 4'hB, 28'($urandom)};
      x.c_bd           = $urandom_range(1) == 1;
      x.c_if_adel      = ($urandom_range(15) == 0);
      x.c_if_refill    = ($urandom_range(15) == 0);
      x.c_if_inv       = ($urandom_range(15) == 0);
      x.c_ri           = ($urandom_range(11) == 0);
      x.c_sys          = ($urandom_range(7) == 0);
      x.c_bp           = ($urandom_range(11) == 0);
      x.c_ov           = ($urandom_range(11) == 0);
      x.c_eret         = ($urandom_range(5) == 0);
      x.c_d_adel       = ($urandom_range(11) == 0);
      x.c_d_ades       = ($urandom_range(11) == 0);
      x.c_d_refill     = ($urandom_range(7) == 0);
      x.c_d_inv        = ($urandom_range(9) == 0);
      x.c_d_mod        = ($urandom_range(7) == 0);
      x.c_d_store      = $urandom_range(1) == 1;
      x.c_dvaddr       = $urandom;
      x.allow_int      = $urandom_range(1) == 1;
      x.interrupt_flag = ($urandom_range(3) == 0) ? 8'($urandom) : 8'h00;
      x.sr_bev         = ($urandom_range(3) == 0);
      x.sr_exl         = $urandom_range(1) == 1;
      x.ebase          = {20'($urandom), 12'h000};
      x.epc            = $urandom;
      cycle(x, g, m, hg, hm);
      chk_out("random_out", g, m);
      chk_hw("random_hw", hg, hm);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
